// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants, defaults and the stall-decode helper for the MEM/WB pipeline register.
// Optional MEM_WB_PERF_CNT_EN build adds retire/bubble counters in the top.
package mem_wb_pipe_pkg;

  localparam logic STOP      = 1'b1;
  localparam logic NOSTOP    = 1'b0;
  localparam logic RSTENABLE = 1'b1;

  localparam logic [63:0] ZERO_64 = '0;

  localparam int unsigned DEF_XLEN   = 64;
  localparam int unsigned DEF_GPR_AW = 6;
  localparam int unsigned DEF_CSR_AW = 12;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_ADVANCE
  } stall_act_e;

  // Flush dominates; a stalled stage only bubbles when its consumer is free.
  function automatic stall_act_e decode_stall(input logic flush,
                                              input logic stall_here,
                                              input logic stall_down);
    if (flush)
      return ACT_BUBBLE;
    if (stall_here == NOSTOP)
      return ACT_ADVANCE;
    if (stall_down == NOSTOP)
      return ACT_BUBBLE;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_lane.sv
// Single-lane MEM/WB register: valid, pc, rd, write enable and data with
// bubble/advance/hold controls. The write enable arrives already qualified.
module wb_lane_reg
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = DEF_XLEN,
  parameter int unsigned GPR_AW = DEF_GPR_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              advance,
  input  logic              hold,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic [GPR_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_w_ena,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_pc,
  output logic [GPR_AW-1:0] wb_rd_addr,
  output logic              wb_rd_w_ena,
  output logic [XLEN-1:0]   wb_wdata
);

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE || bubble) begin
      wb_valid    <= 1'b0;
      wb_pc       <= '0;
      wb_rd_addr  <= '0;
      wb_rd_w_ena <= 1'b0;
      wb_wdata    <= '0;
    end else if (advance && !hold) begin
      wb_valid    <= mem_valid;
      wb_pc       <= mem_pc;
      wb_rd_addr  <= mem_rd_addr;
      wb_rd_w_ena <= mem_rd_w_ena;
      wb_wdata    <= mem_wdata;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register for a multi-lane core: stall/flush handling, x0 suppression,
// youngest-lane-wins GPR conflict masking and the lane-0 CSR channel. Macro: MEM_WB_PERF_CNT_EN.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned LANES   = 2,
  parameter int unsigned GPR_AW  = DEF_GPR_AW,
  parameter int unsigned CSR_AW  = DEF_CSR_AW,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic [LANES-1:0]        mem_valid,
  input  logic [LANES*XLEN-1:0]   mem_pc,
  input  logic [LANES*GPR_AW-1:0] mem_rd_addr,
  input  logic [LANES-1:0]        mem_rd_w_ena,
  input  logic [LANES*XLEN-1:0]   mem_wdata,
  input  logic [CSR_AW-1:0]       mem_csr_w_addr,
  input  logic                    mem_csr_w_ena,
  input  logic [XLEN-1:0]         mem_csr_wdata,
  output logic [LANES-1:0]        wb_valid,
  output logic [LANES*XLEN-1:0]   wb_pc,
  output logic [LANES*GPR_AW-1:0] wb_rd_addr,
  output logic [LANES-1:0]        wb_rd_w_ena,
  output logic [LANES*XLEN-1:0]   wb_wdata,
  output logic [CSR_AW-1:0]       wb_csr_w_addr,
  output logic                    wb_csr_w_ena,
`ifdef MEM_WB_PERF_CNT_EN
  output logic [63:0]             retire_cnt,
  output logic [63:0]             bubble_cnt,
`endif
  output logic [XLEN-1:0]         wb_csr_wdata
);

  if (STAGE + 1 >= STALL_W || LANES < 1 || LANES > 4) begin : g_bad_cfg
    $error("mem_wb_pipe: illegal STAGE/STALL_W or LANES configuration");
  end

  stall_act_e act;
  logic       bubble;
  logic       advance;
  logic       hold;
  logic       unused_stall;

  assign act          = decode_stall(flush, stall[STAGE], stall[STAGE+1]);
  assign bubble       = (act == ACT_BUBBLE);
  assign advance      = (act == ACT_ADVANCE);
  assign hold         = (act == ACT_HOLD);
  assign unused_stall = ^stall;

  logic [LANES-1:0] qual;
  logic [LANES-1:0] keep;

  // An older lane loses its enable if any younger lane writes the same rd.
  always_comb begin
    qual = mem_rd_w_ena & mem_valid;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mem_rd_addr[i*GPR_AW +: GPR_AW] == '0)
        qual[i] = 1'b0;
    end
    keep = qual;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (qual[j] && mem_rd_addr[j*GPR_AW +: GPR_AW] == mem_rd_addr[i*GPR_AW +: GPR_AW])
          keep[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    wb_lane_reg #(
      .XLEN   (XLEN),
      .GPR_AW (GPR_AW)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .bubble       (bubble),
      .advance      (advance),
      .hold         (hold),
      .mem_valid    (mem_valid[g]),
      .mem_pc       (mem_pc[g*XLEN +: XLEN]),
      .mem_rd_addr  (mem_rd_addr[g*GPR_AW +: GPR_AW]),
      .mem_rd_w_ena (keep[g]),
      .mem_wdata    (mem_wdata[g*XLEN +: XLEN]),
      .wb_valid     (wb_valid[g]),
      .wb_pc        (wb_pc[g*XLEN +: XLEN]),
      .wb_rd_addr   (wb_rd_addr[g*GPR_AW +: GPR_AW]),
      .wb_rd_w_ena  (wb_rd_w_ena[g]),
      .wb_wdata     (wb_wdata[g*XLEN +: XLEN])
    );
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE || bubble) begin
      wb_csr_w_addr <= '0;
      wb_csr_w_ena  <= 1'b0;
      wb_csr_wdata  <= '0;
    end else if (advance) begin
      wb_csr_w_addr <= mem_csr_w_addr;
      wb_csr_w_ena  <= mem_csr_w_ena & mem_valid[0];
      wb_csr_wdata  <= mem_csr_wdata;
    end
  end

`ifdef MEM_WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      retire_cnt <= ZERO_64;
      bubble_cnt <= ZERO_64;
    end else if (bubble) begin
      bubble_cnt <= bubble_cnt + 64'd1;
    end else if (advance) begin
      retire_cnt <= retire_cnt + 64'($countones(mem_valid));
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus randomized traffic
// compared against a per-register "last writer wins" reference model.
module tb_mem_wb_pipe;

  localparam int XLEN    = 64;
  localparam int LANES   = 2;
  localparam int GPR_AW  = 6;
  localparam int CSR_AW  = 12;
  localparam int STALL_W = 6;
  localparam int STAGE   = 4;

  logic                    clk;
  logic                    rst;
  logic [STALL_W-1:0]      stall;
  logic                    flush;
  logic [LANES-1:0]        mem_valid;
  logic [LANES*XLEN-1:0]   mem_pc;
  logic [LANES*GPR_AW-1:0] mem_rd_addr;
  logic [LANES-1:0]        mem_rd_w_ena;
  logic [LANES*XLEN-1:0]   mem_wdata;
  logic [CSR_AW-1:0]       mem_csr_w_addr;
  logic                    mem_csr_w_ena;
  logic [XLEN-1:0]         mem_csr_wdata;
  logic [LANES-1:0]        wb_valid;
  logic [LANES*XLEN-1:0]   wb_pc;
  logic [LANES*GPR_AW-1:0] wb_rd_addr;
  logic [LANES-1:0]        wb_rd_w_ena;
  logic [LANES*XLEN-1:0]   wb_wdata;
  logic [CSR_AW-1:0]       wb_csr_w_addr;
  logic                    wb_csr_w_ena;
  logic [XLEN-1:0]         wb_csr_wdata;
`ifdef MEM_WB_PERF_CNT_EN
  logic [63:0]             retire_cnt;
  logic [63:0]             bubble_cnt;
`endif

  mem_wb_pipe #(
    .XLEN    (XLEN),
    .LANES   (LANES),
    .GPR_AW  (GPR_AW),
    .CSR_AW  (CSR_AW),
    .STALL_W (STALL_W),
    .STAGE   (STAGE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_w_ena   (mem_rd_w_ena),
    .mem_wdata      (mem_wdata),
    .mem_csr_w_addr (mem_csr_w_addr),
    .mem_csr_w_ena  (mem_csr_w_ena),
    .mem_csr_wdata  (mem_csr_wdata),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_rd_addr     (wb_rd_addr),
    .wb_rd_w_ena    (wb_rd_w_ena),
    .wb_wdata       (wb_wdata),
    .wb_csr_w_addr  (wb_csr_w_addr),
    .wb_csr_w_ena   (wb_csr_w_ena),
`ifdef MEM_WB_PERF_CNT_EN
    .retire_cnt     (retire_cnt),
    .bubble_cnt     (bubble_cnt),
`endif
    .wb_csr_wdata   (wb_csr_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [LANES-1:0]        e_valid;
  logic [LANES*XLEN-1:0]   e_pc;
  logic [LANES*GPR_AW-1:0] e_rd;
  logic [LANES-1:0]        e_ena;
  logic [LANES*XLEN-1:0]   e_wdata;
  logic [CSR_AW-1:0]       e_csr_addr;
  logic                    e_csr_ena;
  logic [XLEN-1:0]         e_csr_wdata;
  logic [63:0]             e_retire;
  logic [63:0]             e_bubble;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear_outputs();
    e_valid     = '0;
    e_pc        = '0;
    e_rd        = '0;
    e_ena       = '0;
    e_wdata     = '0;
    e_csr_addr  = '0;
    e_csr_ena   = 1'b0;
    e_csr_wdata = '0;
  endtask

  // Applies the update rules to the values present on the inputs at the clock edge.
  task automatic model_update();
    logic [(1<<GPR_AW)-1:0] claimed;
    logic [GPR_AW-1:0]      rd;
    logic                   wr;
    if (rst) begin
      model_clear_outputs();
      e_retire = '0;
      e_bubble = '0;
    end else if (flush || (stall[STAGE] && !stall[STAGE+1])) begin
      model_clear_outputs();
      e_bubble = e_bubble + 1;
    end else if (!stall[STAGE]) begin
      claimed = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
        rd = mem_rd_addr[i*GPR_AW +: GPR_AW];
        wr = mem_rd_w_ena[i] && mem_valid[i] && (rd != 0);
        e_valid[i]                    = mem_valid[i];
        e_pc[i*XLEN +: XLEN]          = mem_pc[i*XLEN +: XLEN];
        e_rd[i*GPR_AW +: GPR_AW]      = rd;
        e_wdata[i*XLEN +: XLEN]       = mem_wdata[i*XLEN +: XLEN];
        e_ena[i]                      = wr && !claimed[rd];
        if (wr) claimed[rd] = 1'b1;
        if (mem_valid[i]) e_retire = e_retire + 1;
      end
      e_csr_addr  = mem_csr_w_addr;
      e_csr_ena   = mem_csr_w_ena && mem_valid[0];
      e_csr_wdata = mem_csr_wdata;
    end
  endtask

  task automatic compare_all();
    check("valid",     wb_valid,      e_valid);
    check("pc",        wb_pc,         e_pc);
    check("rd",        wb_rd_addr,    e_rd);
    check("rd_ena",    wb_rd_w_ena,   e_ena);
    check("wdata",     wb_wdata,      e_wdata);
    check("csr_addr",  wb_csr_w_addr, e_csr_addr);
    check("csr_ena",   wb_csr_w_ena,  e_csr_ena);
    check("csr_wdata", wb_csr_wdata,  e_csr_wdata);
`ifdef MEM_WB_PERF_CNT_EN
    check("retire",    retire_cnt,    e_retire);
    check("bubble",    bubble_cnt,    e_bubble);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst            = 1'b0;
    stall          = '0;
    flush          = 1'b0;
    mem_valid      = '0;
    mem_pc         = '0;
    mem_rd_addr    = '0;
    mem_rd_w_ena   = '0;
    mem_wdata      = '0;
    mem_csr_w_addr = '0;
    mem_csr_w_ena  = 1'b0;
    mem_csr_wdata  = '0;
  endtask

  task automatic rand_inputs();
    rst   = ($urandom_range(0, 39) == 0);
    flush = ($urandom_range(0, 9) == 0);
    stall = STALL_W'($urandom);
    stall[STAGE]   = ($urandom_range(0, 9) < 4);
    stall[STAGE+1] = ($urandom_range(0, 9) < 5);
    mem_valid    = LANES'($urandom);
    mem_rd_w_ena = LANES'($urandom);
    for (int i = 0; i < LANES; i++) begin
      mem_rd_addr[i*GPR_AW +: GPR_AW] = GPR_AW'($urandom_range(0, 5));
      mem_pc[i*XLEN +: XLEN]          = {$urandom, $urandom};
      mem_wdata[i*XLEN +: XLEN]       = {$urandom, $urandom};
    end
    mem_csr_w_addr = CSR_AW'($urandom);
    mem_csr_w_ena  = 1'($urandom);
    mem_csr_wdata  = {$urandom, $urandom};
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    mem_valid = '1;
    mem_rd_w_ena = '1;
    mem_rd_addr = {GPR_AW'(3), GPR_AW'(4)};
    tick();
    check("reset_valid", wb_valid, 0);
    check("reset_ena",   wb_rd_w_ena, 0);

    // Basic advance
    idle_inputs();
    mem_valid = 2'b01;
    mem_rd_w_ena = 2'b01;
    mem_rd_addr[GPR_AW-1:0] = 6'd5;
    mem_wdata[XLEN-1:0] = 64'hDEAD;
    tick();
    check("adv_rd0",    wb_rd_addr[GPR_AW-1:0], 5);
    check("adv_ena0",   wb_rd_w_ena[0], 1);
    check("adv_wdata0", wb_wdata[XLEN-1:0], 64'hDEAD);
    check("adv_valid0", wb_valid[0], 1);

    // Bubble
    stall = 6'b010000;
    tick();
    check("bubble_rd",  wb_rd_addr, 0);
    check("bubble_val", wb_valid, 0);

    // Load rd=7 then hold for three cycles while inputs change
    stall = '0;
    mem_rd_addr[GPR_AW-1:0] = 6'd7;
    tick();
    stall = 6'b110000;
    mem_rd_addr[GPR_AW-1:0] = 6'd12;
    mem_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_rd0",  wb_rd_addr[GPR_AW-1:0], 7);
      check("hold_ena0", wb_rd_w_ena[0], 1);
    end

    // Flush overrides hold
    flush = 1'b1;
    tick();
    check("flush_valid", wb_valid, 0);
    check("flush_rd",    wb_rd_addr, 0);
    flush = 1'b0;
    stall = '0;

    // x0 suppression
    mem_valid = 2'b01;
    mem_rd_w_ena = 2'b01;
    mem_rd_addr = '0;
    tick();
    check("x0_ena0", wb_rd_w_ena[0], 0);

    // Same-rd conflict
    mem_valid = 2'b11;
    mem_rd_w_ena = 2'b11;
    mem_rd_addr = {GPR_AW'(9), GPR_AW'(9)};
    tick();
    check("conflict_ena", wb_rd_w_ena, 2'b10);

    // CSR on invalid lane 0
    mem_valid = 2'b10;
    mem_csr_w_ena = 1'b1;
    mem_csr_w_addr = 12'h300;
    tick();
    check("csr_inv_ena",  wb_csr_w_ena, 0);
    check("csr_inv_addr", wb_csr_w_addr, 12'h300);

    // Counter sequence: reset, 3 advances with both lanes valid, 2 bubbles, reset
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_valid = 2'b11;
    repeat (3) tick();
    stall = 6'b010000;
    repeat (2) tick();
`ifdef MEM_WB_PERF_CNT_EN
    check("cnt_retire6", retire_cnt, 6);
    check("cnt_bubble2", bubble_cnt, 2);
`endif
    stall = 6'b110000;
    rst = 1'b1;
    tick();
`ifdef MEM_WB_PERF_CNT_EN
    check("cnt_rst_retire", retire_cnt, 0);
    check("cnt_rst_bubble", bubble_cnt, 0);
`endif
    check("rst_mid_stall_valid", wb_valid, 0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      rand_inputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
